// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, requester count
// and default geometry of the CPU data memory.
package data_mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned NUM_REQ       = 2;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MEM_DEPTH = 11;

  function automatic logic [NUM_REQ-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way round-robin winner select: on a tie the port not served last wins.
module rr_pick2
  import data_mem_arb_defs::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic               valid_o,
  output logic               winner_idx_o
);

  always_comb begin
    valid_o      = |req_i;
    winner_idx_o = (&req_i) ? ~last_i : req_i[1];
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-cycle CPU data memory.
// Optional address range check enabled by defining DATA_MEM_ARB_RANGE_CHECK_EN.
module data_mem_arbiter
  import data_mem_arb_defs::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ-1:0]        we_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [NUM_REQ-1:0]        done_out,
  output logic [DATA_W-1:0]         rdata_out,
  output logic [NUM_REQ-1:0]        err_out,
  output logic                      mem_we_out,
  output logic [ADDR_W-1:0]         mem_addr_out,
  output logic [DATA_W-1:0]         mem_wdata_out,
  input  logic [DATA_W-1:0]         mem_rdata_in
);

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_e              state_q;
  logic                last_q;
  logic                win_q;
  logic                cmd_we_q;
  logic                cmd_oor_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_we_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [NUM_REQ-1:0]  err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                pick_valid;
  logic                pick_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_oor;

  rr_pick2 u_pick (
    .req_i        (req_in),
    .last_i       (last_q),
    .valid_o      (pick_valid),
    .winner_idx_o (pick_idx)
  );

  // Winner's command fields; only consumed when latched in IDLE, so req_in
  // never reaches an output without passing through a register.
  always_comb begin
    sel_we    = we_in[pick_idx];
    sel_addr  = pick_idx ? addr_in[ADDR_W +: ADDR_W]  : addr_in[0 +: ADDR_W];
    sel_wdata = pick_idx ? wdata_in[DATA_W +: DATA_W] : wdata_in[0 +: DATA_W];
    sel_oor   = RANGE_CHECK && (32'(sel_addr) >= MEM_DEPTH);
  end

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses
  // non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_oor_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      // Pulse outputs default low; each state raises only what it owns.
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q     <= ST_ACCESS;
            win_q       <= pick_idx;
            cmd_we_q    <= sel_we;
            cmd_oor_q   <= sel_oor;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we & ~sel_oor;
            gnt_q       <= port_onehot(pick_idx);
          end
        end
        ST_ACCESS: begin
          if (!cmd_we_q) begin
            rdata_q <= cmd_oor_q ? '0 : mem_rdata_in;
          end
          done_q  <= port_onehot(win_q);
          err_q   <= cmd_oor_q ? port_onehot(win_q) : '0;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          last_q  <= win_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_out       = gnt_q;
  assign done_out      = done_q;
  assign err_out       = err_q;
  assign rdata_out     = rdata_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data memory and a
// scoreboard of expected completions checked whenever done_out pulses.
module tb_data_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 11;
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req, we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt_out, done_out, err_out;
  logic [DW-1:0]   rdata_out, mem_wdata_out, mem_rdata;
  logic            mem_we_out;
  logic [AW-1:0]   mem_addr_out;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  typedef struct {
    logic [1:0]    port_oh;
    logic          is_read;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cnt = 0;
  int last_done_cyc = -1;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_in        (req),
    .we_in         (we),
    .addr_in       (addr),
    .wdata_in      (wdata),
    .gnt_out       (gnt_out),
    .done_out      (done_out),
    .rdata_out     (rdata_out),
    .err_out       (err_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
  end
  always @(posedge clk) if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
  assign mem_rdata = mem[mem_addr_out];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (mem_we_out) we_cnt++;
    if (done_out != 2'b00) begin
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_done", {62'd0, done_out}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_port", {62'd0, done_out}, {62'd0, e.port_oh});
        check("err", {62'd0, err_out}, e.err ? {62'd0, e.port_oh} : 64'd0);
        if (e.is_read) check("rdata", {32'd0, rdata_out}, {32'd0, e.rdata});
      end
    end
  end

  task automatic push_exp(input int port, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t e;
    logic oor;
    oor = RC && (int'(a) >= DEPTH);
    e.port_oh = (port == 1) ? 2'b10 : 2'b01;
    e.is_read = ~w;
    e.rdata   = oor ? '0 : ref_mem[a];
    e.err     = oor;
    if (w && !oor) ref_mem[a] = d;
    sb.push_back(e);
  endtask

  task automatic drive(input int port, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[port] = r;
    we[port]  = w;
    addr[port*AW +: AW]  = a;
    wdata[port*DW +: DW] = d;
  endtask

  task automatic wait_gnt(input logic [1:0] mask, output int c, output logic [1:0] g);
    logic hit = 1'b0;
    c = -1;
    g = 2'b00;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if ((gnt_out & mask) != 2'b00) begin
        hit = 1'b1;
        c = cyc;
        g = gnt_out;
      end
    end
    if (!hit) check("gnt_timeout", {63'd0, hit}, 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int c, cg, base;
    logic [1:0] g;
    logic [AW-1:0] a12;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + i * 32'h0101;
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00; addr = '0; wdata = '0;

    // Reset values, with both ports already requesting reads.
    drive(0, 1'b1, 1'b0, 8'd1, '0);
    drive(1, 1'b1, 1'b0, 8'd2, '0);
    repeat (2) @(negedge clk);
    check("rst_gnt", {62'd0, gnt_out}, 64'd0);
    check("rst_done", {62'd0, done_out}, 64'd0);
    check("rst_err", {62'd0, err_out}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we_out}, 64'd0);
    check("rst_rdata", {32'd0, rdata_out}, 64'd0);
    check("rst_mem_addr", {56'd0, mem_addr_out}, 64'd0);
    check("rst_mem_wdata", {32'd0, mem_wdata_out}, 64'd0);

    // Held tie alternates 0,1,0 with grants three cycles apart.
    push_exp(0, 1'b0, 8'd1, '0);
    push_exp(1, 1'b0, 8'd2, '0);
    push_exp(0, 1'b0, 8'd1, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    c = -1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(2'b11, cg, g);
      check("rr_gnt", {62'd0, g}, (k == 1) ? 64'd2 : 64'd1);
      if (k > 0) check("rr_spacing", 64'(cg - c), 64'd3);
      c = cg;
    end
    req = 2'b00;
    wait_drain();

    // Port 1 write 0xDEADBEEF to 5, then read it back.
    base = we_cnt;
    push_exp(1, 1'b1, 8'd5, 32'hDEAD_BEEF);
    drive(1, 1'b1, 1'b1, 8'd5, 32'hDEAD_BEEF);
    wait_gnt(2'b10, cg, g);
    check("wr_mem_we", {63'd0, mem_we_out}, 64'd1);
    check("wr_mem_addr", {56'd0, mem_addr_out}, 64'd5);
    check("wr_mem_wdata", {32'd0, mem_wdata_out}, 64'hDEAD_BEEF);
    req[1] = 1'b0;
    wait_drain();
    check("wr_we_pulses", 64'(we_cnt - base), 64'd1);
    check("hold_mem_addr", {56'd0, mem_addr_out}, 64'd5);
    check("hold_mem_we", {63'd0, mem_we_out}, 64'd0);
    push_exp(1, 1'b0, 8'd5, '0);
    drive(1, 1'b1, 1'b0, 8'd5, '0);
    wait_gnt(2'b10, cg, g);
    req[1] = 1'b0;
    wait_drain();

    // Port 0 read of 3: latency, then a write must leave rdata_out alone.
    c = cyc;
    push_exp(0, 1'b0, 8'd3, '0);
    drive(0, 1'b1, 1'b0, 8'd3, '0);
    wait_gnt(2'b01, cg, g);
    check("rd_gnt_latency", 64'(cg - c), 64'd1);
    req[0] = 1'b0;
    wait_drain();
    check("rd_done_latency", 64'(last_done_cyc - c), 64'd2);
    push_exp(0, 1'b1, 8'd7, 32'h0BAD_F00D);
    drive(0, 1'b1, 1'b1, 8'd7, 32'h0BAD_F00D);
    wait_gnt(2'b01, cg, g);
    req[0] = 1'b0;
    wait_drain();
    check("rdata_kept", {32'd0, rdata_out}, {32'd0, ref_mem[3]});
    check("mem7", {32'd0, mem[7]}, 64'h0BAD_F00D);

    // Out-of-range write to 12, then read it back.
    a12 = 8'd12;
    base = we_cnt;
    push_exp(0, 1'b1, a12, 32'hCAFE_0012);
    drive(0, 1'b1, 1'b1, a12, 32'hCAFE_0012);
    wait_gnt(2'b01, cg, g);
    req[0] = 1'b0;
    wait_drain();
    check("oor_we_pulses", 64'(we_cnt - base), RC ? 64'd0 : 64'd1);
    check("mem12", {32'd0, mem[a12]}, {32'd0, ref_mem[a12]});
    push_exp(0, 1'b0, a12, '0);
    drive(0, 1'b1, 1'b0, a12, '0);
    wait_gnt(2'b01, cg, g);
    req[0] = 1'b0;
    wait_drain();

    // Reset during ACCESS of a port 1 write: no completion, last_q restored.
    drive(1, 1'b1, 1'b1, 8'd9, 32'h5555_AAAA);
    wait_gnt(2'b10, cg, g);
    rst_n = 1'b0;
    req = 2'b00;
    ref_mem[9] = 32'h5555_AAAA;
    @(negedge clk);
    check("mid_rst_gnt", {62'd0, gnt_out}, 64'd0);
    check("mid_rst_done", {62'd0, done_out}, 64'd0);
    check("mid_rst_err", {62'd0, err_out}, 64'd0);
    check("mid_rst_mem_we", {63'd0, mem_we_out}, 64'd0);
    check("mid_rst_mem_addr", {56'd0, mem_addr_out}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", {62'd0, done_out}, 64'd0);
    check("mem9", {32'd0, mem[9]}, {32'd0, ref_mem[9]});
    push_exp(0, 1'b0, 8'd4, '0);
    push_exp(1, 1'b0, 8'd6, '0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'd4, '0);
    drive(1, 1'b1, 1'b0, 8'd6, '0);
    wait_gnt(2'b11, cg, g);
    check("post_rst_tie", {62'd0, g}, 64'd1);
    req[0] = 1'b0;
    wait_gnt(2'b11, cg, g);
    check("post_rst_second", {62'd0, g}, 64'd2);
    req[1] = 1'b0;
    wait_drain();

    // Port 1 raises its request during port 0's RESP.
    push_exp(0, 1'b0, 8'd2, '0);
    drive(0, 1'b1, 1'b0, 8'd2, '0);
    wait_gnt(2'b01, cg, g);
    req[0] = 1'b0;
    c = -1;
    for (int i = 0; i < 10 && c < 0; i++) begin
      @(negedge clk);
      if (done_out[0]) c = cyc;
    end
    check("resp_seen", {63'd0, c >= 0}, 64'd1);
    push_exp(1, 1'b0, 8'd10, '0);
    drive(1, 1'b1, 1'b0, 8'd10, '0);
    wait_gnt(2'b10, cg, g);
    check("resp_req_gnt_delay", 64'(cg - c), 64'd2);
    req[1] = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer for the CPU data memory (synchronous write, combinational read, 8-bit word address, 32-bit data). Port 0 is the CPU load/store unit; port 1 is the debug/loader port. The block picks one requester round-robin, drives the memory for exactly one cycle, and returns a registered completion with read data. It sits between both requesters and the single `data_memory` instance.

## Interface

Parameters:
- `ADDR_W`, 8: memory word-address width.
- `DATA_W`, 32: data width.
- `MEM_DEPTH`, 11: number of implemented words; used by the range check.

Ports:
- `clk_in`  in  1  single clock, rising edge.
- `rst_n_in`  in  1  reset, synchronous, active-low.
- `req_in`  in  2  request, bit i = port i. Held high until `gnt_out[i]` is seen.
- `we_in`  in  2  1 = write, 0 = read, per port. Stable while req is high.
- `addr_in`  in  2*ADDR_W  port i address in slice `[i*ADDR_W +: ADDR_W]`.
- `wdata_in`  in  2*DATA_W  port i write data in slice `[i*DATA_W +: DATA_W]`.
- `gnt_out`  out  2  one-cycle pulse: command for port i accepted.
- `done_out`  out  2  one-cycle pulse: access for port i complete.
- `rdata_out`  out  DATA_W  read data, valid with `done_out` of a read.
- `err_out`  out  2  one-cycle pulse with `done_out`: address out of range.
- `mem_we_out`  out  1  to memory `write_en_in`.
- `mem_addr_out`  out  ADDR_W  to memory `addr_in`.
- `mem_wdata_out`  out  DATA_W  to memory `data_in`.
- `mem_rdata_in`  in  DATA_W  from memory `data_out`.

## Operation

- FSM with three states: IDLE, ACCESS, RESP.
- IDLE: if any `req_in` bit is high, choose the winner, latch its we, addr and wdata into command registers, record the winner index, and go to ACCESS. Otherwise stay in IDLE.
- Winner selection is round-robin. `last_q` holds the most recently served port.
  - Both requesting: the port other than `last_q` wins.
  - One requesting: that port wins.
- ACCESS:
  - `gnt_out[w]` = 1.
  - `mem_addr_out` and `mem_wdata_out` come from the command registers.
  - `mem_we_out` = latched we, gated by the range check.
  - For a read, capture `mem_rdata_in` into `rdata_out` at the end of the cycle.
  - Go to RESP.
- RESP:
  - `done_out[w]` = 1, and `err_out[w]` = 1 if out of range.
  - `last_q` <= w.
  - Go to IDLE.
- Requester rules:
  - Drop or change `req_in[i]` only after the cycle in which `gnt_out[i]` = 1.
  - Requests are sampled only in IDLE. A new request raised during RESP is served on the next IDLE cycle.
- Outside ACCESS:
  - `mem_we_out` = 0.
  - `mem_addr_out` and `mem_wdata_out` hold the last command (no toggling).
- `rdata_out` holds its value until the next read completes. A write does not change it.
- A request deasserted while in IDLE before being sampled is simply not served. This is legal.

## Timing

- Reset (`rst_n_in` = 0 at a clock edge):
  - state = IDLE, `last_q` = 1 (so port 0 wins the first tie).
  - `gnt_out`, `done_out`, `err_out`, `mem_we_out` = 0.
  - `rdata_out`, `mem_addr_out`, `mem_wdata_out` = 0.
- Reset mid-access, in ACCESS or RESP: the in-flight command is dropped and no `done_out` is issued. A write whose ACCESS cycle already ended has completed in memory.
- Latency: request sampled in IDLE at cycle N → `gnt_out` at N+1 (memory is written at the end of N+1) → `done_out` and `rdata_out` at N+2.
- Throughput: one access per 3 cycles. A continuously requesting pair alternates 0,1,0,1.
- All outputs are registered, or decoded from state plus registers only. There is no combinational path from `req_in` to any output.

## Configuration

- `DATA_MEM_ARB_RANGE_CHECK_EN` defined:
  - An address >= MEM_DEPTH forces `mem_we_out` = 0 in ACCESS.
  - A read of such an address returns `rdata_out` = 0.
  - `err_out[w]` pulses with `done_out[w]`.
- Not defined:
  - Addresses pass through unchecked.
  - `err_out` is tied to 0.

## Structure

- Shared header/package `data_mem_arb_defs` holds:
  - State encodings: ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2.
  - NUM_REQ = 2.
  - Default ADDR_W, DATA_W, MEM_DEPTH.
- One sub-module, `rr_pick2`: combinational winner select from `req_in[1:0]` and `last_q`, producing `valid` and `winner_idx`.
- FSM, command registers and range check live in the top level.

## Test plan

- Reset with `req_in` = 2'b11 held → after reset release, port 0 granted first, then port 1, then port 0. `gnt_out` sequence 01, 10, 01, each 3 cycles apart.
- Port 1 writes 0xDEADBEEF to address 5, then reads address 5 → `mem_we_out` high for exactly 1 cycle with `mem_addr_out` = 5. The read `done_out[1]` arrives with `rdata_out` = 0xDEADBEEF, `err_out` = 0.
- Port 0 read of address 3 while port 1 is idle → `gnt_out[0]` at N+1, `done_out[0]` at N+2, `rdata_out` = memory word 3. `rdata_out` is unchanged by a following write.
- With the macro defined, port 0 writes address 12 → `mem_we_out` never rises. `done_out[0]` and `err_out[0]` pulse together, and memory is unchanged. Without the macro, `err_out` stays 0.
- `rst_n_in` pulled low during ACCESS of a write → next cycle state is IDLE, all pulse outputs are 0, no `done_out` is issued, and `last_q` is reset so port 0 wins the next tie.
- Port 1 raises `req_in` during port 0's RESP → port 1 is sampled in the following IDLE and granted exactly 2 cycles after port 0's `done_out`.
